// File: rtl/avr_gpio_port.sv
// ---------------------------------------------------------------------------
// avr_gpio_port
//   AVR-style GPIO port on the core I/O bus: PORTx / DDRx / PINx plus a
//   pin-change mask (PCMSK) and pin-change flag (PCIF) driving a level irq.
//   Each port bit is an independent lane (pin synchroniser, previous sample,
//   PORT/DDR/PCMSK bits). The top level decodes the bus, collects lane change
//   bits into the flag and muxes read data.
//
// Ports
//   clk        core clock
//   reset      asynchronous, active-high reset
//   io_addr    I/O-space address from the core
//   io_wdata   write data
//   io_we      write strobe, one cycle per write
//   io_re      read strobe; io_rdata is zero when low
//   io_rdata   combinational read data (zero when not addressed, OR-combinable)
//   port_out   PORTx register contents to the pad wrapper
//   ddr_out    DDRx register contents to the pad wrapper
//   pin_in     asynchronous pad inputs
//   irq        pin-change interrupt request (level, = PCIF)
//   irq_ack    core interrupt acknowledge, clears PCIF
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// avr_gpio_lane
//   One port bit. Holds the two-flop pad synchroniser, the previous synced
//   sample for edge detection, and the PORT/DDR/PCMSK bits.
//
// Ports
//   clk, reset  clock / async active-high reset
//   pin         raw pad input bit
//   wr_port     load port bit from wbit
//   wr_tgl      toggle port bit where wbit is 1 (PINx write)
//   wr_ddr      load ddr bit from wbit
//   wr_mask     load mask bit from wbit
//   wbit        write data bit for this lane
//   port_q      PORT bit
//   ddr_q       DDR bit
//   mask_q      PCMSK bit
//   sync_q      synchronised pad value (second sync stage)
//   chg         masked change on this bit in the current cycle
// ---------------------------------------------------------------------------
module avr_gpio_lane (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    input  logic wr_port,
    input  logic wr_tgl,
    input  logic wr_ddr,
    input  logic wr_mask,
    input  logic wbit,
    output logic port_q,
    output logic ddr_q,
    output logic mask_q,
    output logic sync_q,
    output logic chg
);
    logic sync1;
    logic prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync_q <= 1'b0;
            prev   <= 1'b0;
            port_q <= 1'b0;
            ddr_q  <= 1'b0;
            mask_q <= 1'b0;
        end else begin
            sync1  <= pin;
            sync_q <= sync1;
            prev   <= sync_q;
            // wr_port and wr_tgl are decoded from distinct addresses and
            // never both active.
            if (wr_port)
                port_q <= wbit;
            else if (wr_tgl)
                port_q <= port_q ^ wbit;
            if (wr_ddr)
                ddr_q <= wbit;
            if (wr_mask)
                mask_q <= wbit;
        end
    end

    // Any edge (rising or falling) on an enabled bit counts as a change.
    assign chg = (sync_q ^ prev) & mask_q;
endmodule

module avr_gpio_port #(
    parameter int          WIDTH      = 8,
    parameter logic [5:0]  ADDR_PCMSK = 6'h15,
    parameter logic [5:0]  ADDR_PIN   = 6'h16,
    parameter logic [5:0]  ADDR_DDR   = 6'h17,
    parameter logic [5:0]  ADDR_PORT  = 6'h18,
    parameter logic [5:0]  ADDR_PCIF  = 6'h14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       io_addr,
    input  logic [WIDTH-1:0] io_wdata,
    input  logic             io_we,
    input  logic             io_re,
    output logic [WIDTH-1:0] io_rdata,
    output logic [WIDTH-1:0] port_out,
    output logic [WIDTH-1:0] ddr_out,
    input  logic [WIDTH-1:0] pin_in,
    output logic             irq,
    input  logic             irq_ack
);
    typedef struct packed {
        logic             we;
        logic             re;
        logic [5:0]       addr;
        logic [WIDTH-1:0] wdata;
    } io_req_t;

    io_req_t          req;
    logic             wr_port;
    logic             wr_tgl;
    logic             wr_ddr;
    logic             wr_mask;
    logic             pcif_clr;
    logic             pcif;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] chg;

    assign req = '{we: io_we, re: io_re, addr: io_addr, wdata: io_wdata};

    // Write decode; a simultaneous read does not suppress the write.
    assign wr_port  = req.we && (req.addr == ADDR_PORT);
    assign wr_tgl   = req.we && (req.addr == ADDR_PIN);
    assign wr_ddr   = req.we && (req.addr == ADDR_DDR);
    assign wr_mask  = req.we && (req.addr == ADDR_PCMSK);
    assign pcif_clr = irq_ack || (req.we && (req.addr == ADDR_PCIF) && req.wdata[0]);

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        avr_gpio_lane u_lane (
            .clk     (clk),
            .reset   (reset),
            .pin     (pin_in[i]),
            .wr_port (wr_port),
            .wr_tgl  (wr_tgl),
            .wr_ddr  (wr_ddr),
            .wr_mask (wr_mask),
            .wbit    (req.wdata[i]),
            .port_q  (port_out[i]),
            .ddr_q   (ddr_out[i]),
            .mask_q  (mask_q[i]),
            .sync_q  (sync_q[i]),
            .chg     (chg[i])
        );
    end

    // Set has priority over clear so a change landing in the ack cycle is
    // not lost; the core simply sees irq stay high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pcif <= 1'b0;
        else if (|chg)
            pcif <= 1'b1;
        else if (pcif_clr)
            pcif <= 1'b0;
    end

    assign irq = pcif;

    // Unaddressed or unstrobed reads return zero so several peripherals can
    // be OR-combined onto the core's read bus.
    always_comb begin
        io_rdata = '0;
        if (req.re) begin
            unique case (req.addr)
                ADDR_PIN:   io_rdata = sync_q;
                ADDR_PORT:  io_rdata = port_out;
                ADDR_DDR:   io_rdata = ddr_out;
                ADDR_PCMSK: io_rdata = mask_q;
                ADDR_PCIF:  io_rdata[0] = pcif;
                default:    io_rdata = '0;
            endcase
        end
    end
endmodule

// File: doc/avr_gpio_port.md
Name: avr_gpio_port

Overview:
- Memory-mapped AVR-style GPIO port on the CPU I/O bus; provides the PORTx/DDRx/PINx register triplet plus a pin-change interrupt.
- Sits between the core's I/O-space decode and the SoC port pins.
- Drives port_b/ddr_b outward and presents the synchronised pin_b value to the core.
- Replaces the bare register bits currently inside the SoC, so multiple ports can be instantiated.

Parameters:
- WIDTH, 8, number of port bits.
- ADDR_PCMSK, 6'h15, I/O address of the pin-change mask register.
- ADDR_PIN, 6'h16, I/O address of PINx.
- ADDR_DDR, 6'h17, I/O address of DDRx.
- ADDR_PORT, 6'h18, I/O address of PORTx.
- ADDR_PCIF, 6'h14, I/O address of the pin-change flag register (bit 0 = flag).

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- io_addr  in  6  I/O-space address from the core.
- io_wdata  in  WIDTH  write data.
- io_we  in  1  write strobe; one cycle per write.
- io_re  in  1  read strobe; qualifies io_rdata.
- io_rdata  out  WIDTH  read data, combinational.
- port_out  out  WIDTH  PORTx register contents.
- ddr_out  out  WIDTH  DDRx register contents.
- pin_in  in  WIDTH  asynchronous pad inputs.
- irq  out  1  pin-change interrupt request, level.
- irq_ack  in  1  core interrupt acknowledge; clears the flag.

Behaviour:
- Reset (async, active-high): PORT=0, DDR=0, PCMSK=0, PCIF=0, both synchroniser stages=0, previous-sample register=0.
- Reset effect on outputs: port_out=0, ddr_out=0, irq=0. Reset mid-operation discards any in-flight change detection.
- Synchroniser: two flops, sync1<=pin_in, sync2<=sync1 on every posedge. pin_in is visible in sync2 after 2 cycles.
- prev: prev<=sync2 every cycle.
- Change vector: change = (sync2 ^ prev) & PCMSK.
- Write at ADDR_PORT (io_we): PORT<=io_wdata. Visible on port_out the next cycle.
- Write at ADDR_DDR (io_we): DDR<=io_wdata. Visible on ddr_out the next cycle.
- Write at ADDR_PCMSK (io_we): PCMSK<=io_wdata. The new mask applies from the next cycle's change computation.
- Write at ADDR_PIN (io_we): PORT<=PORT ^ io_wdata, i.e. AVR toggle-by-writing-1. PIN itself is read-only.
- Write at ADDR_PCIF (io_we): writing 1 to bit 0 clears the flag; writing 0 has no effect.
- Writes to any other address are ignored. io_we with io_re also asserted is treated as a write; the read data is still driven.
- Flag set: PCIF<=1 when |change is true.
- Flag clear: caused by irq_ack or a PCIF write-1.
- Set and clear in the same cycle: set wins, so no edge is lost.
- irq = PCIF, registered. irq rises the cycle after the change cycle, i.e. 3 cycles after the pin_in edge is sampled.
- Read data when io_re is high:
  - ADDR_PIN returns sync2.
  - ADDR_PORT returns PORT.
  - ADDR_DDR returns DDR.
  - ADDR_PCMSK returns PCMSK.
  - ADDR_PCIF returns {0..., PCIF}.
  - Any other address, or io_re low, returns 0, so the core can OR-combine multiple peripherals.
- Reads have no side effects.
- Pad direction: the block does not tristate. port_out and ddr_out go to the pad wrapper.
- PIN reflects the pad regardless of DDR, matching AVR; with DDR=1 the pad wrapper loops PORT back.
- Bit-count wrap: none. All registers are exactly WIDTH bits; io_wdata bits above WIDTH do not exist.

Test Plan:
- Reset/defaults: assert reset asynchronously mid-cycle with PORT=8'hA5 previously written -> port_out, ddr_out and irq go to 0 immediately, without waiting for clk. Reads of every address return 0.
- Register write/readback: write 8'h3C to 6'h18 and 8'h0F to 6'h17 -> next cycle port_out=8'h3C and ddr_out=8'h0F; reads return the same values. Read of 6'h20 returns 0.
- PIN toggle: PORT=8'hF0, write 8'h81 to 6'h16 -> port_out=8'h71 next cycle. A second identical write gives 8'hF0.
- Synchroniser latency: change pin_in from 8'h00 to 8'h55 just after edge N -> reads of 6'h16 return 0 through edge N+1 and 8'h55 from edge N+2 onward.
- Pin-change interrupt:
  - Setup: PCMSK=8'h01, pin_in bit1 toggles -> irq stays 0.
  - pin_in bit0 rises -> irq=1 three cycles later; reading 6'h14 returns 8'h01.
  - Write 8'h01 to 6'h14 -> irq=0 next cycle.
- Set/clear collision: hold irq_ack high in the exact cycle a new masked change is detected -> irq remains 1. Dropping irq_ack with no further changes, then pulsing irq_ack once -> irq=0.
